// File: rtl/rsa_operand_loader.sv
// Purpose : reads one operand block (message / key / modulus) from the 256x32
//           operand SRAM and streams it to the RSA datapath.
// Latency : start at T -> first read at T+1, first out_valid at T+2, word k at
//           T+2+k with out_ready high, done one cycle after the last handshake.
// Backpr. : at most two words in flight (SRAM output + 2-entry buffer); reads
//           stall while buffer occupancy + inflight read reaches 2.
// Ports   : clk/rst (async active-high); start/sel command; busy/done/err status;
//           sram_en/sram_addr/sram_data read port; out_valid/out_ready/out_data/
//           out_idx/out_last word stream.
module rsa_operand_loader #(
  parameter int         WORDS    = 64,
  parameter logic [7:0] MSG_BASE = 8'd0,
  parameter logic [7:0] KEY_BASE = 8'd64,
  parameter logic [7:0] MOD_BASE = 8'd128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  sel,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        sram_en,
  output logic [7:0]  sram_addr,
  input  logic [31:0] sram_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [5:0]  out_idx,
  output logic        out_last
);

  localparam logic [6:0] WORDS_C  = 7'(WORDS);
  localparam logic [6:0] LAST_C   = 7'(WORDS - 1);
  localparam logic [5:0] LAST_IDX = LAST_C[5:0];

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  state_t      r_state, w_next;
  logic [7:0]  r_base;
  logic [6:0]  r_icnt;
  logic [6:0]  r_acnt;
  logic        r_inflight;
  logic [5:0]  r_iidx;
  logic [1:0]  r_cnt;
  logic [31:0] r_q0_dat, r_q1_dat;
  logic [5:0]  r_q0_idx, r_q1_idx;
  logic        r_err;

  logic        w_accept;
  logic        w_issue;
  logic        w_hs;
  logic        w_push;
  logic        w_pop;
  logic        w_empty;
  logic [7:0]  w_sel_base;

  assign w_accept = (r_state == S_IDLE) && start && (sel != 2'd3);
  assign w_empty  = (r_cnt == 2'd0);

  // The inflight read occupies a slot: it will land in the buffer unless it
  // is consumed straight off the SRAM output in the capture cycle.
  assign w_issue = (r_state == S_FETCH) && (r_icnt < WORDS_C) &&
                   (({1'b0, r_cnt} + {2'b0, r_inflight}) < 3'd2);

  assign sram_en   = w_issue;
  assign sram_addr = w_issue ? (r_base + {1'b0, r_icnt}) : 8'd0;

  // With the buffer empty the word arriving from SRAM is presented directly,
  // which is what gives first out_valid one cycle after the first read.
  assign out_valid = !w_empty || r_inflight;
  assign out_data  = !w_empty ? r_q0_dat : (r_inflight ? sram_data : 32'd0);
  assign out_idx   = !w_empty ? r_q0_idx : (r_inflight ? r_iidx : 6'd0);
  assign out_last  = out_valid && (out_idx == LAST_IDX);

  assign w_hs   = out_valid && out_ready;
  assign w_push = r_inflight && !(w_hs && w_empty);
  assign w_pop  = w_hs && !w_empty;

  assign err = r_err;

  always_comb begin
    w_sel_base = MSG_BASE;
    case (sel)
      2'd1:    w_sel_base = KEY_BASE;
      2'd2:    w_sel_base = MOD_BASE;
      default: w_sel_base = MSG_BASE;
    endcase
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = S_FETCH;
      end
      S_FETCH: begin
        busy = 1'b1;
        if (w_issue && (r_icnt == LAST_C)) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (w_hs && (r_acnt == LAST_C)) w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_base     <= 8'd0;
      r_icnt     <= 7'd0;
      r_acnt     <= 7'd0;
      r_inflight <= 1'b0;
      r_iidx     <= 6'd0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_err      <= (r_state == S_IDLE) && start && (sel == 2'd3);
      r_inflight <= w_issue;
      if (w_issue) r_iidx <= r_icnt[5:0];
      if (w_accept) begin
        r_base <= w_sel_base;
        r_icnt <= 7'd0;
        r_acnt <= 7'd0;
      end else begin
        if (w_issue) r_icnt <= r_icnt + 7'd1;
        if (w_hs)    r_acnt <= r_acnt + 7'd1;
      end
    end
  end

  // 2-entry buffer, q0 is the head. Simultaneous push/pop keeps occupancy
  // and shifts q1 forward so ordering is preserved.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= 2'd0;
      r_q0_dat <= 32'd0;
      r_q0_idx <= 6'd0;
      r_q1_dat <= 32'd0;
      r_q1_idx <= 6'd0;
    end else begin
      case ({w_push, w_pop})
        2'b11: begin
          if (r_cnt == 2'd1) begin
            r_q0_dat <= sram_data;
            r_q0_idx <= r_iidx;
          end else begin
            r_q0_dat <= r_q1_dat;
            r_q0_idx <= r_q1_idx;
            r_q1_dat <= sram_data;
            r_q1_idx <= r_iidx;
          end
        end
        2'b10: begin
          if (r_cnt == 2'd0) begin
            r_q0_dat <= sram_data;
            r_q0_idx <= r_iidx;
          end else begin
            r_q1_dat <= sram_data;
            r_q1_idx <= r_iidx;
          end
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_q0_dat <= r_q1_dat;
          r_q0_idx <= r_q1_idx;
          r_cnt    <= r_cnt - 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_operand_loader.sv
// Purpose : directed self-checking bench for rsa_operand_loader with a
//           behavioural 256x32 SRAM (mem[a] = 32'hA500_0000 + a).
// Ports   : drives clk/rst/start/sel/out_ready/sram_data; observes all outputs.
module tb_rsa_operand_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  sel = 2'd0;
  logic        busy, done, err, sram_en;
  logic [7:0]  sram_addr;
  logic [31:0] sram_data = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [5:0]  out_idx;
  logic        out_last;

  logic [31:0] mem [256];

  int n_chk = 0;
  int n_err = 0;

  rsa_operand_loader dut (
    .clk(clk), .rst(rst), .start(start), .sel(sel),
    .busy(busy), .done(done), .err(err),
    .sram_en(sram_en), .sram_addr(sram_addr), .sram_data(sram_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (sram_en) sram_data <= mem[sram_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: ready always 1; mode 1: ready 1,0,0,1 repeating; mode 2: ready 0
  // for 10 cycles after start then 1. inj pulses start mid-transfer.
  task automatic run_xfer(input logic [1:0] s, input logic [7:0] eb, input int mode, input bit inj);
    int k = 0, cyc, first_v = -1, last_hs = -1, en_cnt = 0, gaps = 0;
    int done_cyc = -1;
    bit err_seen = 0, prev_v = 0, prev_r = 0, got_done = 0;
    logic [31:0] prev_d = 0;
    logic [5:0]  prev_i = 0;
    start = 1'b1;
    sel   = s;
    tick();
    start = 1'b0;
    cyc = 1;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    while (cyc < 400) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (((cyc - 1) % 4) == 0) || (((cyc - 1) % 4) == 3);
        default: out_ready = (cyc > 10);
      endcase
      start = 1'b0;
      if (inj && cyc == 5) begin
        start = 1'b1;
        sel   = 2'd0;
      end
      if (mode == 2 && cyc == 11) check("stall_reads", en_cnt, 2);
      err_seen |= err;
      if (sram_en) begin
        check("addr", {24'd0, sram_addr}, {24'd0, eb} + en_cnt);
        check("outstanding", {31'd0, (en_cnt + 1 - k) <= 2}, 32'd1);
        en_cnt++;
      end
      if (prev_v && !prev_r) begin
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        check("hold_data", out_data, prev_d);
        check("hold_idx", {26'd0, out_idx}, {26'd0, prev_i});
      end
      if (out_valid && first_v < 0) first_v = cyc;
      if (out_valid && out_ready) begin
        check("data", out_data, 32'hA500_0000 + {24'd0, eb} + k);
        check("idx", {26'd0, out_idx}, k);
        check("last", {31'd0, out_last}, {31'd0, k == 63});
        if (last_hs >= 0 && cyc != last_hs + 1) gaps++;
        last_hs = cyc;
        k++;
      end
      prev_v = out_valid;
      prev_r = out_ready;
      prev_d = out_data;
      prev_i = out_idx;
      tick();
      cyc++;
      if (done) begin
        got_done = 1;
        done_cyc = cyc;
        break;
      end
    end
    start = 1'b0;
    if (!got_done) check("done_timeout", 32'd0, 32'd1);
    check("word_count", k, 64);
    check("read_count", en_cnt, 64);
    check("done_busy", {31'd0, busy}, 32'd0);
    check("done_after_last", done_cyc, last_hs + 1);
    check("no_err", {31'd0, err_seen}, 32'd0);
    if (mode == 0) begin
      check("first_valid", first_v, 2);
      check("last_hs", last_hs, 65);
      check("done_cycle", done_cyc, 66);
    end
    if (mode != 1) check("gaps", gaps, 0);
    tick();
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_done", {31'd0, done}, 32'd0);
  endtask

  initial begin
    int w;
    for (int a = 0; a < 256; a++) mem[a] = 32'hA500_0000 + a;

    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", {busy, done, err, sram_en, out_valid, out_last, 12'd0, sram_addr, 2'd0, out_idx},
          32'd0);
    check("reset_data", out_data, 32'd0);
    rst = 1'b0;
    tick();

    run_xfer(2'd1, 8'd64, 0, 1'b1);
    run_xfer(2'd2, 8'd128, 1, 1'b0);
    run_xfer(2'd0, 8'd0, 2, 1'b0);

    // reserved select
    start = 1'b1;
    sel   = 2'd3;
    check("err_no_en", {31'd0, sram_en}, 32'd0);
    tick();
    start = 1'b0;
    check("err_pulse", {31'd0, err}, 32'd1);
    check("err_busy", {31'd0, busy}, 32'd0);
    check("err_sram_en", {31'd0, sram_en}, 32'd0);
    tick();
    check("err_clear", {31'd0, err}, 32'd0);
    check("err_stay_idle", {31'd0, busy | sram_en}, 32'd0);

    // reset in the middle of a key transfer
    out_ready = 1'b1;
    start = 1'b1;
    sel   = 2'd1;
    tick();
    start = 1'b0;
    w = 0;
    while (!(out_valid && out_idx == 6'd20) && w < 100) begin
      tick();
      w++;
    end
    check("rst_reach_word20", {26'd0, out_idx}, 32'd20);
    #1 rst = 1'b1;
    #1;
    check("rst_outs", {busy, done, err, sram_en, out_valid, out_last, 12'd0, sram_addr, 2'd0, out_idx},
          32'd0);
    check("rst_data", out_data, 32'd0);
    @(posedge clk);
    #1;
    check("rst_held_outs", {busy, done, sram_en, out_valid}, 32'd0);
    rst = 1'b0;
    run_xfer(2'd2, 8'd128, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
